// File: rtl/meas_scheduler_if.sv
// Signal bundle between the measurement scheduler and its surroundings:
// host/auto request controls, the engine handshake, and status outputs.
interface meas_scheduler_if #(
    parameter int PERIOD_W = 16
);
    // requests and controls
    logic                host_req_i;
    logic [1:0]          host_mode_i;
    logic                auto_en_i;
    logic [PERIOD_W-1:0] auto_period_i;
    logic [1:0]          auto_mode_i;
    logic                abort_i;
    logic                irq_ack_i;
    // engine completion
    logic                meas_done_i;
    logic                meas_err_i;
    logic [15:0]         meas_result_i;
    // engine start and status
    logic                meas_start_o;
    logic [1:0]          meas_mode_o;
    logic                busy_o;
    logic [15:0]         result_o;
    logic                result_src_o;
    logic                result_err_o;
    logic                irq_o;
    logic                overrun_o;
    logic                timeout_o;

    // driven by the environment (host, timer controls, engine)
    modport master (
        output host_req_i, host_mode_i, auto_en_i, auto_period_i, auto_mode_i,
        output abort_i, irq_ack_i, meas_done_i, meas_err_i, meas_result_i,
        input  meas_start_o, meas_mode_o, busy_o, result_o, result_src_o,
        input  result_err_o, irq_o, overrun_o, timeout_o
    );

    // the scheduler itself
    modport slave (
        input  host_req_i, host_mode_i, auto_en_i, auto_period_i, auto_mode_i,
        input  abort_i, irq_ack_i, meas_done_i, meas_err_i, meas_result_i,
        output meas_start_o, meas_mode_o, busy_o, result_o, result_src_o,
        output result_err_o, irq_o, overrun_o, timeout_o
    );
endinterface

// File: rtl/meas_scheduler.sv
// Measurement scheduler: arbitrates host one-shot and periodic auto requests
// for the single measurement engine, issues a start pulse per grant, guards
// the conversion with a watchdog and captures the result with a level irq.
module meas_scheduler #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int PERIOD_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    meas_scheduler_if.slave  bus
);
    // Watchdog must be able to hold TIMEOUT_CYCLES itself.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                host_pend_reg;
    logic [1:0]          host_mode_reg;
    logic                auto_pend_reg;
    logic [PERIOD_W-1:0] timer_reg;
    logic [WD_W-1:0]     wdog_reg;
    logic [1:0]          mode_reg;
    logic                src_reg;
    logic [15:0]         cap_data_reg;
    logic                cap_err_reg;
    logic [15:0]         result_reg;
    logic                result_src_reg;
    logic                result_err_reg;
    logic                irq_reg;
    logic                overrun_reg;
    logic                timeout_reg;

    logic timer_run, auto_tick, host_req_ok;
    logic grant_host, grant_auto, done_hit, wd_hit, capture_fire;

    // Event decode shared by the FSM and the datapath. abort_i masks every
    // event that would otherwise move work forward this cycle.
    assign timer_run    = bus.auto_en_i && (bus.auto_period_i != '0);
    assign auto_tick    = timer_run && (timer_reg == bus.auto_period_i - PERIOD_W'(1));
    assign host_req_ok  = bus.host_req_i && !bus.abort_i;
    assign grant_host   = (state_reg == ST_IDLE) && !bus.abort_i && host_pend_reg;
    assign grant_auto   = (state_reg == ST_IDLE) && !bus.abort_i && !host_pend_reg && auto_pend_reg;
    assign done_hit     = (state_reg == ST_WAIT) && !bus.abort_i && bus.meas_done_i;
    assign wd_hit       = (state_reg == ST_WAIT) && !bus.abort_i && !bus.meas_done_i
                          && (wdog_reg == WD_LAST);
    assign capture_fire = (state_reg == ST_CAPTURE) && !bus.abort_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic; abort returns to IDLE from anywhere.
    always_comb begin
        state_next = state_reg;
        if (bus.abort_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:    if (host_pend_reg || auto_pend_reg) state_next = ST_START;
                ST_START:   state_next = ST_WAIT;
                ST_WAIT:    if (done_hit || wd_hit) state_next = ST_CAPTURE;
                ST_CAPTURE: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state.
    always_comb begin
        bus.meas_start_o = (state_reg == ST_START);
        bus.busy_o       = (state_reg != ST_IDLE);
    end

    // Host pending flag and its mode; a request arriving while still pending
    // keeps the older mode unless that older one is being granted right now.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            host_pend_reg <= 1'b0;
            host_mode_reg <= 2'd0;
        end else begin
            if (bus.abort_i) host_pend_reg <= 1'b0;
            else             host_pend_reg <= (host_pend_reg && !grant_host) || host_req_ok;
            if (host_req_ok && (!host_pend_reg || grant_host))
                host_mode_reg <= bus.host_mode_i;
        end
    end

    // Auto-trigger period counter and auto pending flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_reg     <= '0;
            auto_pend_reg <= 1'b0;
        end else begin
            if (!timer_run)     timer_reg <= '0;
            else if (auto_tick) timer_reg <= '0;
            else                timer_reg <= timer_reg + PERIOD_W'(1);
            if (bus.abort_i) auto_pend_reg <= 1'b0;
            else             auto_pend_reg <= (auto_pend_reg && !grant_auto) || auto_tick;
        end
    end

    // Grant bookkeeping, watchdog and the pending capture value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_reg     <= 2'd0;
            src_reg      <= 1'b0;
            wdog_reg     <= '0;
            cap_data_reg <= 16'h0000;
            cap_err_reg  <= 1'b0;
        end else begin
            if (grant_host) begin
                mode_reg <= host_mode_reg;
                src_reg  <= 1'b0;
            end else if (grant_auto) begin
                mode_reg <= bus.auto_mode_i;
                src_reg  <= 1'b1;
            end
            if (bus.abort_i || state_reg == ST_START) wdog_reg <= '0;
            else if (state_reg == ST_WAIT)            wdog_reg <= wdog_reg + WD_W'(1);
            if (done_hit) begin
                cap_data_reg <= bus.meas_result_i;
                cap_err_reg  <= bus.meas_err_i;
            end else if (wd_hit) begin
                cap_data_reg <= 16'hFFFF;
                cap_err_reg  <= 1'b1;
            end
        end
    end

    // Result registers, level interrupt and sticky flags; a new event in
    // the acknowledge cycle wins over the clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_reg     <= 16'h0000;
            result_src_reg <= 1'b0;
            result_err_reg <= 1'b0;
            irq_reg        <= 1'b0;
            overrun_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            if (capture_fire) begin
                result_reg     <= cap_data_reg;
                result_src_reg <= src_reg;
                result_err_reg <= cap_err_reg;
            end
            irq_reg     <= capture_fire || (irq_reg && !bus.irq_ack_i);
            overrun_reg <= (host_req_ok && host_pend_reg)
                           || (auto_tick && auto_pend_reg && !bus.abort_i)
                           || (overrun_reg && !bus.irq_ack_i);
            timeout_reg <= wd_hit || (timeout_reg && !bus.irq_ack_i);
        end
    end

    assign bus.meas_mode_o  = mode_reg;
    assign bus.result_o     = result_reg;
    assign bus.result_src_o = result_src_reg;
    assign bus.result_err_o = result_err_reg;
    assign bus.irq_o        = irq_reg;
    assign bus.overrun_o    = overrun_reg;
    assign bus.timeout_o    = timeout_reg;
endmodule

// File: tb/tb_meas_scheduler.sv
// Testbench for meas_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a conversion-level reference model.
module tb_meas_scheduler;
    localparam int TMO = 100;
    localparam int PW  = 16;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    meas_scheduler_if #(.PERIOD_W(PW)) bus();

    meas_scheduler #(.TIMEOUT_CYCLES(TMO), .PERIOD_W(PW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model: pending requests, conversion age, captured results
    bit          m_hp, m_ap;
    logic [1:0]  m_hmode;
    int          m_timer;
    int          m_age;      // -1 no conversion, 0 start cycle, k>=1 k-th wait cycle
    bit          m_cap;      // capture cycle
    logic [1:0]  m_cmode;
    bit          m_csrc;
    logic [15:0] m_cdata;
    bit          m_cerr;
    logic [15:0] m_res;
    bit          m_rsrc, m_rerr, m_irq, m_ovr, m_tmo;

    // engine emulation
    int          eng_cnt = 0;
    int          eng_lat = 10;
    logic [15:0] eng_result = 16'h0000;
    logic        eng_err = 1'b0;
    bit          rand_eng = 1'b0;
    bit          spur = 1'b0;
    int          n_start = 0;

    task automatic m_reset();
        m_hp = 0; m_ap = 0; m_hmode = 2'd0; m_timer = 0; m_age = -1; m_cap = 0;
        m_cmode = 2'd0; m_csrc = 0; m_cdata = 16'h0; m_cerr = 0;
        m_res = 16'h0; m_rsrc = 0; m_rerr = 0; m_irq = 0; m_ovr = 0; m_tmo = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_step();
        int per;
        bit run, tk, ab, ack, rq, idle, g_h, g_a, in_wait, fin_done, fin_to, cap_now;
        per      = int'(bus.auto_period_i);
        run      = bus.auto_en_i && per != 0;
        tk       = run && (m_timer == per - 1);
        ab       = bus.abort_i;
        ack      = bus.irq_ack_i;
        rq       = bus.host_req_i && !ab;
        idle     = (m_age < 0) && !m_cap;
        g_h      = idle && !ab && m_hp;
        g_a      = idle && !ab && !m_hp && m_ap;
        in_wait  = (m_age >= 1);
        fin_done = in_wait && !ab && bus.meas_done_i;
        fin_to   = in_wait && !ab && !bus.meas_done_i && (m_age == TMO);
        cap_now  = m_cap && !ab;

        // interrupt and sticky flags
        m_ovr = (rq && m_hp) || (!ab && tk && m_ap) || (m_ovr && !ack);
        m_tmo = fin_to || (m_tmo && !ack);
        m_irq = cap_now || (m_irq && !ack);
        // publish the previously captured conversion
        if (cap_now) begin
            m_res = m_cdata; m_rsrc = m_csrc; m_rerr = m_cerr;
        end
        if (fin_done) begin
            m_cdata = bus.meas_result_i; m_cerr = bus.meas_err_i;
        end else if (fin_to) begin
            m_cdata = 16'hFFFF; m_cerr = 1;
        end
        // conversion progress
        if (ab) begin
            m_age = -1; m_cap = 0;
        end else if (m_cap) begin
            m_cap = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (in_wait) begin
            if (fin_done || fin_to) begin m_age = -1; m_cap = 1; end
            else m_age = m_age + 1;
        end else if (g_h || g_a) begin
            m_age   = 0;
            m_cmode = g_h ? m_hmode : bus.auto_mode_i;
            m_csrc  = g_a;
        end
        // pending requests
        if (rq && (!m_hp || g_h)) m_hmode = bus.host_mode_i;
        m_hp = ab ? 1'b0 : ((m_hp && !g_h) || rq);
        m_ap = ab ? 1'b0 : ((m_ap && !g_a) || tk);
        m_timer = run ? (tk ? 0 : m_timer + 1) : 0;
    endtask

    task automatic drive_engine();
        bit done;
        done = 0;
        if (bus.meas_start_o === 1'b1) begin
            if (rand_eng) eng_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 30));
            eng_cnt = eng_lat;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            done = (eng_cnt == 0);
        end
        bus.meas_done_i = done || spur;
        if (rand_eng) begin
            bus.meas_result_i = 16'($urandom);
            bus.meas_err_i    = 1'($urandom_range(0, 1));
        end else begin
            bus.meas_result_i = eng_result;
            bus.meas_err_i    = eng_err;
        end
    endtask

    task automatic compare();
        chk("meas_start", bus.meas_start_o, (m_age == 0));
        chk("meas_mode",  bus.meas_mode_o,  m_cmode);
        chk("busy",       bus.busy_o,       (m_age >= 0) || m_cap);
        chk("result",     bus.result_o,     m_res);
        chk("result_src", bus.result_src_o, m_rsrc);
        chk("result_err", bus.result_err_o, m_rerr);
        chk("irq",        bus.irq_o,        m_irq);
        chk("overrun",    bus.overrun_o,    m_ovr);
        chk("timeout",    bus.timeout_o,    m_tmo);
        if (bus.meas_start_o === 1'b1) n_start++;
    endtask

    task automatic tick();
        drive_engine();
        model_step();
        @(posedge clk_i);
        #1;
        bus.host_req_i = 1'b0;
        bus.abort_i    = 1'b0;
        bus.irq_ack_i  = 1'b0;
        spur           = 1'b0;
        compare();
    endtask

    // Step until the model reaches its capture cycle, then past it.
    task automatic run_through_capture(input int limit);
        int k;
        k = 0;
        while (!m_cap && k < limit) begin
            tick();
            k++;
        end
        if (!m_cap) begin
            n_vec++;
            n_bad++;
            $error("FAIL capture_bound observed=%0d cycles expected=capture", k);
        end
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"},   bus.meas_start_o, 0);
        chk({tag, "_mode"},    bus.meas_mode_o,  0);
        chk({tag, "_busy"},    bus.busy_o,       0);
        chk({tag, "_result"},  bus.result_o,     0);
        chk({tag, "_src"},     bus.result_src_o, 0);
        chk({tag, "_err"},     bus.result_err_o, 0);
        chk({tag, "_irq"},     bus.irq_o,        0);
        chk({tag, "_overrun"}, bus.overrun_o,    0);
        chk({tag, "_timeout"}, bus.timeout_o,    0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.host_req_i = 0; bus.host_mode_i = 0; bus.auto_en_i = 0; bus.auto_period_i = 0;
        bus.auto_mode_i = 0; bus.abort_i = 0; bus.irq_ack_i = 0;
        bus.meas_done_i = 0; bus.meas_err_i = 0; bus.meas_result_i = 0;
        m_reset();

        // reset state
        #2;
        check_all_zero("rst");
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // 1: single host conversion, mode 2, result 1234 after 10 cycles
        eng_lat = 10; eng_result = 16'h1234; eng_err = 0; n_start = 0;
        bus.host_mode_i = 2'd2; bus.host_req_i = 1'b1;
        tick();
        chk("t1_no_start_yet", bus.meas_start_o, 0);
        tick();
        chk("t1_start_latency", bus.meas_start_o, 1);
        chk("t1_mode", bus.meas_mode_o, 2);
        run_through_capture(40);
        chk("t1_result", bus.result_o, 16'h1234);
        chk("t1_src", bus.result_src_o, 0);
        chk("t1_err", bus.result_err_o, 0);
        chk("t1_irq", bus.irq_o, 1);
        chk("t1_starts", n_start, 1);
        bus.irq_ack_i = 1; tick();

        // 2: host request and auto tick in the same cycle, host served first
        eng_result = 16'h2222; n_start = 0;
        bus.auto_period_i = 16'd50; bus.auto_mode_i = 2'd1; bus.auto_en_i = 1;
        repeat (49) tick();
        bus.host_mode_i = 2'd0; bus.host_req_i = 1'b1;
        tick();
        bus.auto_en_i = 0;
        run_through_capture(40);
        chk("t2_first_src", bus.result_src_o, 0);
        run_through_capture(40);
        chk("t2_second_src", bus.result_src_o, 1);
        chk("t2_auto_mode", bus.meas_mode_o, 1);
        chk("t2_starts", n_start, 2);
        bus.irq_ack_i = 1; tick();

        // 3: engine never completes, watchdog fires
        eng_lat = -1;
        bus.host_mode_i = 2'd3; bus.host_req_i = 1'b1;
        tick();
        run_through_capture(TMO + 20);
        chk("t3_result", bus.result_o, 16'hFFFF);
        chk("t3_err", bus.result_err_o, 1);
        chk("t3_timeout", bus.timeout_o, 1);
        chk("t3_irq", bus.irq_o, 1);
        bus.irq_ack_i = 1; tick();
        chk("t3_irq_cleared", bus.irq_o, 0);
        chk("t3_timeout_cleared", bus.timeout_o, 0);

        // 4: two host requests while busy -> overrun, first pending mode kept
        eng_lat = 10; eng_result = 16'h00A5; n_start = 0;
        bus.host_mode_i = 2'd1; bus.host_req_i = 1'b1;
        tick();
        repeat (4) tick();
        bus.host_mode_i = 2'd3; bus.host_req_i = 1'b1;
        tick();
        repeat (2) tick();
        bus.host_mode_i = 2'd0; bus.host_req_i = 1'b1;
        tick();
        chk("t4_overrun", bus.overrun_o, 1);
        run_through_capture(40);
        run_through_capture(40);
        chk("t4_kept_mode", bus.meas_mode_o, 3);
        repeat (5) tick();
        chk("t4_starts", n_start, 2);
        bus.irq_ack_i = 1; tick();
        chk("t4_overrun_cleared", bus.overrun_o, 0);

        // 5: ack coinciding with capture keeps irq set
        eng_result = 16'h0A0A;
        bus.host_req_i = 1'b1;
        tick();
        while (!m_cap && n_vec < 90000) tick();
        bus.irq_ack_i = 1; tick();
        chk("t5_irq_set_wins", bus.irq_o, 1);
        chk("t5_result", bus.result_o, 16'h0A0A);
        bus.irq_ack_i = 1; tick();
        chk("t5_irq_lone_ack", bus.irq_o, 0);

        // 6: abort in WAIT, late done ignored
        eng_result = 16'h5555;
        bus.host_req_i = 1'b1;
        tick();
        repeat (4) tick();
        bus.abort_i = 1; tick();
        repeat (15) tick();
        chk("t6_irq", bus.irq_o, 0);
        chk("t6_result_kept", bus.result_o, 16'h0A0A);
        chk("t6_busy", bus.busy_o, 0);

        // 6b: reset in WAIT -> outputs zero, nothing generated on release
        bus.host_req_i = 1'b1;
        tick();
        repeat (4) tick();
        chk("t6b_busy_before", bus.busy_o, 1);
        #3 rst_n_i = 1'b0;
        #1;
        check_all_zero("t6b");
        m_reset();
        eng_cnt = 0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        n_start = 0;
        repeat (20) tick();
        chk("t6b_no_start", n_start, 0);
        chk("t6b_no_irq", bus.irq_o, 0);

        // random traffic against the model
        rand_eng = 1;
        for (int i = 0; i < 3000; i++) begin
            bus.host_req_i  = ($urandom_range(0, 15) == 0);
            bus.host_mode_i = 2'($urandom_range(0, 3));
            bus.auto_mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                bus.auto_en_i     = ~bus.auto_en_i;
                bus.auto_period_i = 16'($urandom_range(0, 40));
            end
            bus.abort_i   = ($urandom_range(0, 79) == 0);
            bus.irq_ack_i = ($urandom_range(0, 7) == 0);
            spur          = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
